// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM with a retired-instruction counter.
// Optional build macro MC_BNE_EN adds bne (opcode 000101) as a branch.
module multicycle_controller (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       ShamtSel,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic [3:0] State,
  output logic [15:0] InstrRetired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADDR  = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC     = 4'd6;
  localparam logic [3:0] S_RTYPEWB  = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_IEXEC    = 4'd10;
  localparam logic [3:0] S_IWB      = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_NOR = 4'd7;

  // Returns {legal, shamt_select, alu_op} for an R-type funct field.
  function automatic logic [5:0] funct_decode(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 1'b0, ALU_ADD};
      6'b100010: return {1'b1, 1'b0, ALU_SUB};
      6'b100100: return {1'b1, 1'b0, ALU_AND};
      6'b100101: return {1'b1, 1'b0, ALU_OR};
      6'b101010: return {1'b1, 1'b0, ALU_SLT};
      6'b100111: return {1'b1, 1'b0, ALU_NOR};
      6'b000000: return {1'b1, 1'b1, ALU_SLL};
      6'b000010: return {1'b1, 1'b1, ALU_SRL};
      default:   return {1'b0, 1'b0, ALU_ADD};
    endcase
  endfunction

  function automatic logic [3:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  logic [3:0]  state_r;
  logic [3:0]  next_state_s;
  logic [15:0] retired_r;
  logic        retire_s;
  logic [5:0]  funct_dec_s;
  logic [3:0]  imm_op_s;
  logic        bne_s;

  assign funct_dec_s = funct_decode(Funct);
  assign imm_op_s    = imm_aluop(Opcode);
`ifdef MC_BNE_EN
  assign bne_s = (Opcode == OP_BNE);
`else
  assign bne_s = 1'b0;
`endif

  assign State        = state_r;
  assign InstrRetired = retired_r;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Retirement counter, bumped on the final cycle of every legal instruction.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      retired_r <= 16'd0;
    end else if (retire_s) begin
      retired_r <= retired_r + 16'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Next-state and retire-qualifier decode.
  always_comb begin
    next_state_s = S_FETCH;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        if (Opcode == OP_LW || Opcode == OP_SW) begin
          next_state_s = S_MEMADDR;
        end else if (Opcode == OP_RTYPE) begin
          next_state_s = S_EXEC;
        end else if (Opcode == OP_BEQ || bne_s) begin
          next_state_s = S_BRANCH;
        end else if (Opcode == OP_J) begin
          next_state_s = S_JUMP;
        end else if (Opcode == OP_ADDI || Opcode == OP_ANDI ||
                     Opcode == OP_ORI  || Opcode == OP_SLTI) begin
          next_state_s = S_IEXEC;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMADDR: begin
        if (Opcode == OP_LW) begin
          next_state_s = S_MEMREAD;
        end else if (Opcode == OP_SW) begin
          next_state_s = S_MEMWRITE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMREAD: next_state_s = S_MEMWB;
      S_EXEC:    next_state_s = funct_dec_s[5] ? S_RTYPEWB : S_FETCH;
      S_IEXEC:   next_state_s = S_IWB;
      S_MEMWB, S_MEMWRITE, S_RTYPEWB, S_BRANCH, S_JUMP, S_IWB: begin
        next_state_s = S_FETCH;
        retire_s     = 1'b1;
      end
      default: next_state_s = S_FETCH;
    endcase
  end

  // Moore control decode; everything forced low while Reset is held.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ShamtSel = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    ALUOp    = ALU_ADD;
    if (Reset) begin
      PCWrite = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = 1'b1;
        end
        S_DECODE:  ALUSrcB = 2'b11;
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMREAD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXEC, S_RTYPEWB: begin
          ALUSrcA  = 1'b1;
          ShamtSel = funct_dec_s[4];
          ALUOp    = funct_dec_s[3:0];
          RegWrite = (state_r == S_RTYPEWB);
          RegDst   = (state_r == S_RTYPEWB);
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALU_SUB;
          PCSource = 2'b01;
          PCWrite  = bne_s ? ~Zero : Zero;
        end
        S_JUMP: begin
          PCSource = 2'b10;
          PCWrite  = 1'b1;
        end
        S_IEXEC, S_IWB: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          ALUOp    = imm_op_s;
          RegWrite = (state_r == S_IWB);
        end
        default: PCWrite = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes expected per-cycle
// state/control/count records, a negedge monitor pops and compares them.
module tb_multicycle_controller;

  logic Clk, Reset, Zero;
  logic [5:0] Opcode, Funct;
  logic PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ShamtSel;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, State;
  logic [15:0] InstrRetired;

  multicycle_controller dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ShamtSel(ShamtSel), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .State(State), .InstrRetired(InstrRetired)
  );

`ifdef MC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic [15:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [15:0] model_ret = 16'd0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ShamtSel,ALUSrcB,PCSource,ALUOp}
  function automatic logic [17:0] pack(input logic pcw, iord, mr, mw, irw, m2r, rd, rw, asa, sh,
                                       input logic [1:0] asb, pcs, input logic [3:0] op);
    return {pcw, iord, mr, mw, irw, m2r, rd, rw, asa, sh, asb, pcs, op};
  endfunction

  // R-type reference: returns legal flag, shift flag and ALU op from the funct table.
  function automatic logic [5:0] r_ref(input logic [5:0] fn);
    case (fn)
      6'b100000: return 6'b10_0000;
      6'b100010: return 6'b10_0001;
      6'b100100: return 6'b10_0010;
      6'b100101: return 6'b10_0011;
      6'b101010: return 6'b10_0100;
      6'b100111: return 6'b10_0111;
      6'b000000: return 6'b11_0101;
      6'b000010: return 6'b11_0110;
      default:   return 6'b00_0000;
    endcase
  endfunction

  function automatic logic [3:0] i_ref(input logic [5:0] op);
    case (op)
      6'b001100: return 4'd2;
      6'b001101: return 4'd3;
      6'b001010: return 4'd4;
      default:   return 4'd0;
    endcase
  endfunction

  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op, fn, input logic z);
    logic [5:0] r;
    logic br;
    r  = r_ref(fn);
    br = (BNE_EN && op == 6'b000101) ? ~z : z;
    case (st)
      4'd0:  return pack(1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,4'd0);
      4'd1:  return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,4'd0);
      4'd2:  return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,4'd0);
      4'd3:  return pack(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'd0);
      4'd4:  return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,4'd0);
      4'd5:  return pack(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'd0);
      4'd6:  return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,r[4],2'b00,2'b00,r[3:0]);
      4'd7:  return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,r[4],2'b00,2'b00,r[3:0]);
      4'd8:  return pack(br,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,4'd1);
      4'd9:  return pack(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,4'd0);
      4'd10: return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,i_ref(op));
      4'd11: return pack(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b10,2'b00,i_ref(op));
      default: return 18'd0;
    endcase
  endfunction

  // Called one step after a rising edge with the DUT in FETCH; runs one instruction.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic [3:0] path[$];
    logic retires;
    path = '{4'd0, 4'd1};
    retires = 1'b1;
    if (op == 6'b100011) path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    else if (op == 6'b101011) path = '{4'd0, 4'd1, 4'd2, 4'd5};
    else if (op == 6'b000000) begin
      if (r_ref(fn)[5]) path = '{4'd0, 4'd1, 4'd6, 4'd7};
      else begin path = '{4'd0, 4'd1, 4'd6}; retires = 1'b0; end
    end
    else if (op == 6'b000100 || (BNE_EN && op == 6'b000101)) path = '{4'd0, 4'd1, 4'd8};
    else if (op == 6'b000010) path = '{4'd0, 4'd1, 4'd9};
    else if (op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001010)
      path = '{4'd0, 4'd1, 4'd10, 4'd11};
    else retires = 1'b0;
    Opcode = op; Funct = fn; Zero = z;
    foreach (path[i]) exp_q.push_back('{path[i], exp_ctrl(path[i], op, fn, z), model_ret});
    repeat (path.size()) @(posedge Clk);
    #1;
    if (retires) model_ret = model_ret + 16'd1;
  endtask

  // Scoreboard monitor: one expected record per cycle while the queue is non-empty.
  always @(negedge Clk) begin
    exp_t e;
    logic [17:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
             ALUSrcA, ShamtSel, ALUSrcB, PCSource, ALUOp};
      tests = tests + 3;
      if (State !== e.st) begin
        fails = fails + 1;
        $display("FAIL state: got %0d expected %0d at %0t", State, e.st, $time);
      end
      if (act !== e.ctrl) begin
        fails = fails + 1;
        $display("FAIL ctrl (state %0d): got %b expected %b at %0t", e.st, act, e.ctrl, $time);
      end
      if (InstrRetired !== e.ret) begin
        fails = fails + 1;
        $display("FAIL retired: got %h expected %h at %0t", InstrRetired, e.ret, $time);
      end
    end
  end

  logic [5:0] ops[12];
  logic [5:0] fns[9];

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b000010,
            6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b111111, 6'b000001};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
            6'b100111, 6'b000000, 6'b000010, 6'b111000};
    Reset = 1'b1; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    exp_q.push_back('{4'd0, 18'd0, 16'd0});
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    issue(6'b100011, 6'd0, 1'b0);        // lw
    issue(6'b101011, 6'd0, 1'b0);        // sw
    issue(6'b000000, 6'b000000, 1'b0);   // sll
    issue(6'b000000, 6'b100000, 1'b0);   // add
    issue(6'b000000, 6'b000010, 1'b0);   // srl
    issue(6'b000000, 6'b111111, 1'b0);   // unknown funct
    issue(6'b000100, 6'd0, 1'b1);        // beq taken
    issue(6'b000100, 6'd0, 1'b0);        // beq not taken
    issue(6'b000010, 6'd0, 1'b0);        // j
    issue(6'b001000, 6'd0, 1'b0);
    issue(6'b001100, 6'd0, 1'b0);
    issue(6'b001101, 6'd0, 1'b0);
    issue(6'b001010, 6'd0, 1'b0);
    issue(6'b111111, 6'd0, 1'b0);        // illegal
    issue(6'b000101, 6'd0, 1'b0);        // bne, Zero=0
    issue(6'b000101, 6'd0, 1'b1);

    // Reset asserted while in MEMREAD of a lw.
    Opcode = 6'b100011; Funct = 6'd0; Zero = 1'b0;
    exp_q.push_back('{4'd0, exp_ctrl(4'd0, Opcode, Funct, Zero), model_ret});
    exp_q.push_back('{4'd1, exp_ctrl(4'd1, Opcode, Funct, Zero), model_ret});
    exp_q.push_back('{4'd2, exp_ctrl(4'd2, Opcode, Funct, Zero), model_ret});
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    exp_q.push_back('{4'd3, 18'd0, model_ret});
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_ret = 16'd0;
    issue(6'b000010, 6'd0, 1'b0);

    // Counter wrap: preload to 0xFFFF, then one jump.
    force dut.retired_r = 16'hFFFF;
    #1;
    release dut.retired_r;
    model_ret = 16'hFFFF;
    issue(6'b000010, 6'd0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      issue(ops[$urandom_range(11, 0)], fns[$urandom_range(8, 0)], 1'($urandom_range(1, 0)));
    end

    @(negedge Clk);
    tests = tests + 1;
    if (InstrRetired !== model_ret) begin
      fails = fails + 1;
      $display("FAIL final_count: got %h expected %h", InstrRetired, model_ret);
    end
    tests = tests + 1;
    if (exp_q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Clk  in  1  single system clock; all state updates on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset, sampled on rising Clk.
REQ-003 Opcode  in  6  instruction-register bits [31:26], stable from cycle after FETCH.
REQ-004 Funct  in  6  instruction-register bits [5:0].
REQ-005 Zero  in  1  ALU zero flag, valid combinationally in BRANCH state.
REQ-006 Outputs, each 1 bit unless noted: PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ShamtSel (ALU B = {27'b0,Instr[10:6]}), ALUSrcB[1:0], PCSource[1:0], ALUOp[3:0].
REQ-007 State  out  4  current state code; InstrRetired  out  16  retired-instruction count.

Function
REQ-008 Outputs SHALL be Moore decodes of State plus Opcode/Funct; unlisted outputs are 0 in every state.
REQ-009 Encodings SHALL be: ALUSrcB 00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2; ALUSrcA 0=PC, 1=A; PCSource 00=ALU, 01=ALUOut, 10={PC[31:28],Instr[25:0],2'b00}.
REQ-010 ALUOp SHALL be: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 0101 sll, 0110 srl, 0111 nor.
REQ-011 FETCH(0): MemRead, IRWrite, ALUSrcB=01, ALUOp=add, PCWrite, PCSource=00; -> DECODE.
REQ-012 DECODE(1): ALUSrcB=11, ALUOp=add (branch target into ALUOut); next by Opcode: 100011/101011->MEMADDR, 000000->EXEC, 000100->BRANCH, 000010->JUMP, 001000/001100/001101/001010->IEXEC, other->FETCH.
REQ-013 MEMADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=add; lw->MEMREAD, sw->MEMWRITE.
REQ-014 MEMREAD(3): IorD, MemRead; -> MEMWB(4): RegWrite, MemtoReg, RegDst=0; -> FETCH.
REQ-015 MEMWRITE(5): IorD, MemWrite; -> FETCH.
REQ-016 EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp from Funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor, 000000 sll, 000010 srl); ShamtSel=1 for sll/srl; unknown Funct -> FETCH without writeback; else -> RTYPEWB(7): RegWrite, RegDst=1, MemtoReg=0, Exec ALU controls held; -> FETCH.
REQ-017 BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSource=01, PCWrite=Zero (beq); -> FETCH.
REQ-018 JUMP(9): PCSource=10, PCWrite=1; -> FETCH.
REQ-019 IEXEC(10): ALUSrcA=1, ALUSrcB=10, ALUOp add/and/or/slt for addi/andi/ori/slti; -> IWB(11): RegWrite, RegDst=0, controls held; -> FETCH.
REQ-020 State codes 12-15 unreachable; if entered, SHALL return to FETCH next cycle with all outputs 0.
REQ-021 InstrRetired SHALL increment by 1 on the cycle leaving MEMWB, MEMWRITE, RTYPEWB, BRANCH, JUMP or IWB; wraps 0xFFFF->0x0000; illegal opcode/funct does not count.
REQ-022 Latency: lw 5 cycles, sw/R-type/I-type 4, beq/j 3, illegal 2.

Reset
REQ-023 Reset=1 SHALL force State=FETCH and InstrRetired=0 at next edge, overriding any in-progress instruction (no write/retire that cycle).
REQ-024 While Reset=1, all outputs SHALL decode as FETCH is not active: every control output 0.

Configuration
REQ-025 Macro MC_BNE_EN defined: Opcode 000101 -> BRANCH with PCWrite=~Zero, retired as a branch.
REQ-026 MC_BNE_EN undefined: Opcode 000101 is illegal (DECODE -> FETCH, not counted).

Verification
REQ-027 Reset, then lw (100011) -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; InstrRetired=1.
REQ-028 R-type Funct 000000 -> EXEC shows ALUOp=0101, ShamtSel=1; RTYPEWB RegWrite=1, RegDst=1.
REQ-029 beq with Zero=1 -> PCWrite=1, PCSource=01 in state 8; Zero=0 -> PCWrite=0; both retire.
REQ-030 Opcode 111111 -> states 0,1,0; no RegWrite/MemWrite; InstrRetired unchanged.
REQ-031 Reset asserted in MEMREAD -> next State=0, InstrRetired=0, no RegWrite pulse.
REQ-032 Preload 0xFFFF retirements, one j -> InstrRetired=0x0000; bne with Zero=0 under MC_BNE_EN -> PCWrite=1, without -> illegal path.
